// File: rtl/timer_pkg.sv
// Shared types and constants for the hours/minutes/seconds countdown timer.
package timer_pkg;

  localparam int unsigned FIELD_W = 7;
  localparam int unsigned SEL_W   = 2;

  localparam logic [FIELD_W-1:0] HOUR_LIMIT   = 7'd23;
  localparam logic [FIELD_W-1:0] MINSEC_LIMIT = 7'd59;
  localparam logic [FIELD_W-1:0] ZERO         = 7'd0;

  localparam logic [SEL_W-1:0] SEL_SEC  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_MIN  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_HOUR = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [FIELD_W-1:0] hours;
    logic [FIELD_W-1:0] minutes;
    logic [FIELD_W-1:0] seconds;
  } hms_t;

endpackage

// File: rtl/mod_down_counter.sv
// Single time field: wrapping set-mode up/down adjust plus borrow-chained countdown.
module mod_down_counter
  import timer_pkg::*;
#(
  parameter logic [FIELD_W-1:0] LIMIT = MINSEC_LIMIT
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               load_en,
  input  logic [FIELD_W-1:0] load_val,
  input  logic               load_inc,
  input  logic               load_dec,
  input  logic               dec_en,
  output logic [FIELD_W-1:0] value,
  output logic               is_zero,
  output logic               borrow
);

  logic [FIELD_W-1:0] r_value;

  assign value   = r_value;
  assign is_zero = (r_value == ZERO);
  assign borrow  = dec_en && is_zero;

  // Bulk load beats manual adjust, which beats countdown; inc+dec together is a no-op.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_value <= ZERO;
    end else if (load_en) begin
      r_value <= load_val;
    end else if (load_inc && !load_dec) begin
      r_value <= (r_value == LIMIT) ? ZERO : r_value + 7'd1;
    end else if (load_dec && !load_inc) begin
      r_value <= (r_value == ZERO) ? LIMIT : r_value - 7'd1;
    end else if (dec_en) begin
      r_value <= borrow ? LIMIT : r_value - 7'd1;
    end
  end

endmodule

// File: rtl/countdown_timer_hms.sv
// HH:MM:SS countdown timer with set mode, pause/resume and alarm.
// Define AUTO_RELOAD_EN to reload the last set value on expiry and keep running.
module countdown_timer_hms
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               clear_n,
  input  logic               tick,
  input  logic               mode,
  input  logic [SEL_W-1:0]   field_sel,
  input  logic               manual_increment,
  input  logic               manual_decrement,
  input  logic               start,
  input  logic               stop,
  output logic [FIELD_W-1:0] hours,
  output logic [FIELD_W-1:0] minutes,
  output logic [FIELD_W-1:0] seconds,
  output logic               running,
  output logic               expired,
  output logic               alarm
);

  state_t r_state;
  logic   r_running;
  logic   r_expired;
  logic   r_alarm;

  logic   w_adjust;
  logic   w_run_tick;
  logic   w_last_tick;
  logic   w_time_zero;
  logic   w_reload_load;
  hms_t   w_reload_val;
  logic   w_sec_zero, w_min_zero, w_hour_zero;
  logic   w_sec_borrow, w_min_borrow, w_hour_borrow_unused;

  assign w_adjust    = (r_state == SET) && mode;
  assign w_run_tick  = (r_state == RUN) && tick && !stop;
  assign w_time_zero = w_sec_zero && w_min_zero && w_hour_zero;
  assign w_last_tick = w_run_tick && (seconds == 7'd1) && w_min_zero && w_hour_zero;

`ifdef AUTO_RELOAD_EN
  hms_t r_reload;

  // Snapshot the programmed time as the set session closes.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_reload <= '0;
    end else if ((r_state == SET) && !mode) begin
      r_reload <= '{hours: hours, minutes: minutes, seconds: seconds};
    end
  end

  assign w_reload_val  = r_reload;
  assign w_reload_load = w_last_tick && (r_reload != '0);
`else
  assign w_reload_val  = '0;
  assign w_reload_load = 1'b0;
`endif

  mod_down_counter #(.LIMIT(MINSEC_LIMIT)) u_sec (
    .clk      (clk),
    .clear_n  (clear_n),
    .load_en  (w_reload_load),
    .load_val (w_reload_val.seconds),
    .load_inc (w_adjust && (field_sel == SEL_SEC) && manual_increment),
    .load_dec (w_adjust && (field_sel == SEL_SEC) && manual_decrement),
    .dec_en   (w_run_tick),
    .value    (seconds),
    .is_zero  (w_sec_zero),
    .borrow   (w_sec_borrow)
  );

  mod_down_counter #(.LIMIT(MINSEC_LIMIT)) u_min (
    .clk      (clk),
    .clear_n  (clear_n),
    .load_en  (w_reload_load),
    .load_val (w_reload_val.minutes),
    .load_inc (w_adjust && (field_sel == SEL_MIN) && manual_increment),
    .load_dec (w_adjust && (field_sel == SEL_MIN) && manual_decrement),
    .dec_en   (w_sec_borrow),
    .value    (minutes),
    .is_zero  (w_min_zero),
    .borrow   (w_min_borrow)
  );

  // Hours never borrow while running: RUN is only entered with a nonzero time.
  mod_down_counter #(.LIMIT(HOUR_LIMIT)) u_hour (
    .clk      (clk),
    .clear_n  (clear_n),
    .load_en  (w_reload_load),
    .load_val (w_reload_val.hours),
    .load_inc (w_adjust && (field_sel == SEL_HOUR) && manual_increment),
    .load_dec (w_adjust && (field_sel == SEL_HOUR) && manual_decrement),
    .dec_en   (w_min_borrow),
    .value    (hours),
    .is_zero  (w_hour_zero),
    .borrow   (w_hour_borrow_unused)
  );

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        IDLE, PAUSE: begin
          if (mode) begin
            r_state <= SET;
            r_alarm <= 1'b0;
          end else if (start && !w_time_zero) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_alarm   <= 1'b0;
          end
        end
        SET: begin
          if (!mode) r_state <= IDLE;
        end
        RUN: begin
          if (stop) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
          end else begin
            // start only matters here for acknowledging a reload-mode alarm
            if (start) r_alarm <= 1'b0;
            if (w_last_tick) begin
              r_expired <= 1'b1;
              r_alarm   <= 1'b1;
              if (!w_reload_load) begin
                r_state   <= DONE;
                r_running <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          if (mode) begin
            r_state <= SET;
            r_alarm <= 1'b0;
          end else if (stop) begin
            r_state <= IDLE;
            r_alarm <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign running = r_running;
  assign expired = r_expired;
  assign alarm   = r_alarm;

endmodule

// File: tb/tb_countdown_timer_hms.sv
// Self-checking bench: time-in-seconds reference model, directed scenarios, random soak.
module tb_countdown_timer_hms;

  logic       clk = 1'b0;
  logic       clear_n, tick, mode, manual_increment, manual_decrement, start, stop;
  logic [1:0] field_sel;
  logic [6:0] hours, minutes, seconds;
  logic       running, expired, alarm;

  int total_cnt = 0;
  int bad_cnt   = 0;
  bit chk_en    = 1'b0;

  localparam int ST_IDLE = 0, ST_SET = 1, ST_RUN = 2, ST_PAUSE = 3, ST_DONE = 4;
  int m_st, m_h, m_m, m_s, m_run, m_exp, m_alm, m_rel;

  countdown_timer_hms dut (
    .clk              (clk),
    .clear_n          (clear_n),
    .tick             (tick),
    .mode             (mode),
    .field_sel        (field_sel),
    .manual_increment (manual_increment),
    .manual_decrement (manual_decrement),
    .start            (start),
    .stop             (stop),
    .hours            (hours),
    .minutes          (minutes),
    .seconds          (seconds),
    .running          (running),
    .expired          (expired),
    .alarm            (alarm)
  );

  always #5 clk = ~clk;

  function automatic int tot();
    return m_h * 3600 + m_m * 60 + m_s;
  endfunction

  function automatic void from_tot(input int t);
    m_h = t / 3600;
    m_m = (t / 60) % 60;
    m_s = t % 60;
  endfunction

  function automatic int adj(input int v, input int lim);
    if (manual_increment && !manual_decrement) return (v == lim) ? 0 : v + 1;
    if (manual_decrement && !manual_increment) return (v == 0) ? lim : v - 1;
    return v;
  endfunction

  // Reference model: state advanced from the sampled inputs on each rising edge.
  always @(posedge clk) begin
    if (!clear_n) begin
      m_st = ST_IDLE; m_h = 0; m_m = 0; m_s = 0;
      m_run = 0; m_exp = 0; m_alm = 0; m_rel = 0;
    end else begin
      m_exp = 0;
      case (m_st)
        ST_SET: begin
          if (mode) begin
            case (field_sel)
              2'd0: m_s = adj(m_s, 59);
              2'd1: m_m = adj(m_m, 59);
              2'd2: m_h = adj(m_h, 23);
              default: ;
            endcase
          end else begin
            m_st  = ST_IDLE;
            m_rel = tot();
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (mode) begin
            m_st = ST_SET; m_alm = 0;
          end else if (start && tot() != 0) begin
            m_st = ST_RUN; m_alm = 0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            m_st = ST_PAUSE; m_alm = 0;
          end else begin
            if (start) m_alm = 0;
            if (tick) begin
              from_tot(tot() - 1);
              if (tot() == 0) begin
                m_exp = 1; m_alm = 1;
`ifdef AUTO_RELOAD_EN
                if (m_rel != 0) from_tot(m_rel);
                else m_st = ST_DONE;
`else
                m_st = ST_DONE;
`endif
              end
            end
          end
        end
        ST_DONE: begin
          if (mode) begin
            m_st = ST_SET; m_alm = 0;
          end else if (stop) begin
            m_st = ST_IDLE; m_alm = 0;
          end
        end
        default: m_st = ST_IDLE;
      endcase
      m_run = (m_st == ST_RUN) ? 1 : 0;
    end
  end

  task automatic cmp(input string name, input int got, input int exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model.hours",   int'(hours),   m_h);
      cmp("model.minutes", int'(minutes), m_m);
      cmp("model.seconds", int'(seconds), m_s);
      cmp("model.running", int'(running), m_run);
      cmp("model.expired", int'(expired), m_exp);
      cmp("model.alarm",   int'(alarm),   m_alm);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    tick = 0; mode = 0; field_sel = 2'd3; manual_increment = 0;
    manual_decrement = 0; start = 0; stop = 0;
  endtask

  task automatic set_field(input logic [1:0] sel, input int target);
    field_sel = sel;
    manual_increment = 1;
    for (int i = 0; i < 64; i++) begin
      if ((sel == 2'd0 && m_s == target) || (sel == 2'd1 && m_m == target) ||
          (sel == 2'd2 && m_h == target)) break;
      step();
    end
    manual_increment = 0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    idle_inputs();
    stop = 1; step(); stop = 0;
    mode = 1; step();
    set_field(2'd0, s);
    set_field(2'd1, m);
    set_field(2'd2, h);
    field_sel = 2'd3;
    mode = 0; step();
  endtask

  initial begin
    idle_inputs();
    clear_n = 0;
    step(); step();
    chk_en = 1'b1;
    cmp("reset.hours", int'(hours), 0);
    cmp("reset.alarm", int'(alarm), 0);
    clear_n = 1;

    // Reset in the middle of a countdown discards the time.
    set_time(1, 2, 3);
    start = 1; step(); start = 0;
    cmp("run.running", int'(running), 1);
    cmp("run.time", int'({hours, minutes, seconds}), int'({7'd1, 7'd2, 7'd3}));
    tick = 1; step(); tick = 0;
    clear_n = 0; step(); clear_n = 1;
    cmp("clr.time", int'({hours, minutes, seconds}), 0);
    cmp("clr.running", int'(running), 0);
    start = 1; step(); start = 0;
    cmp("start_zero.running", int'(running), 0);

    // Hours wrap in both directions; simultaneous buttons hold.
    mode = 1; step();
    field_sel = 2'd2;
    manual_decrement = 1; step(); manual_decrement = 0;
    cmp("hour_dec_wrap", int'(hours), 23);
    manual_increment = 1; step();
    cmp("hour_inc_wrap", int'(hours), 0);
    manual_decrement = 1; step();
    cmp("hour_both", int'(hours), 0);
    manual_increment = 0; manual_decrement = 0;
    field_sel = 2'd3; manual_increment = 1; step(); manual_increment = 0;
    cmp("sel_none", int'({hours, minutes, seconds}), 0);
    mode = 0; step();

    // One minute countdown to expiry.
    set_time(0, 1, 0);
    start = 1; step(); start = 0;
    tick = 1; step();
    cmp("min_borrow", int'({minutes, seconds}), int'({7'd0, 7'd59}));
    for (int i = 0; i < 58; i++) step();
    cmp("one_left", int'(seconds), 1);
    step(); tick = 0;
    cmp("expire.pulse", int'(expired), 1);
    cmp("expire.alarm", int'(alarm), 1);
`ifdef AUTO_RELOAD_EN
    cmp("expire.reload", int'({minutes, seconds}), int'({7'd1, 7'd0}));
    cmp("expire.running", int'(running), 1);
`else
    cmp("expire.time", int'({hours, minutes, seconds}), 0);
    cmp("expire.running", int'(running), 0);
`endif
    step();
    cmp("expire.one_cycle", int'(expired), 0);
    cmp("alarm.held", int'(alarm), 1);
    stop = 1; step(); stop = 0;
    cmp("alarm.ack", int'(alarm), 0);

    // Two-level borrow.
    set_time(1, 0, 0);
    start = 1; step(); start = 0;
    tick = 1; step(); tick = 0;
    cmp("hour_borrow", int'({hours, minutes, seconds}), int'({7'd0, 7'd59, 7'd59}));

    // stop beats a coincident tick; resume continues from the held time.
    set_time(0, 0, 10);
    start = 1; step(); start = 0;
    stop = 1; tick = 1; step(); stop = 0; tick = 0;
    cmp("pause.time", int'(seconds), 10);
    cmp("pause.running", int'(running), 0);
    start = 1; step(); start = 0;
    tick = 1; step(); tick = 0;
    cmp("resume.tick", int'(seconds), 9);

    // Short run to expiry; reload behaviour depends on the build.
    set_time(0, 0, 2);
    start = 1; step(); start = 0;
    tick = 1; step(); step(); tick = 0;
    cmp("short.expired", int'(expired), 1);
`ifdef AUTO_RELOAD_EN
    cmp("short.reload", int'(seconds), 2);
    cmp("short.running", int'(running), 1);
`else
    cmp("short.seconds", int'(seconds), 0);
    cmp("short.running", int'(running), 0);
`endif

    // Random soak against the model.
    for (int i = 0; i < 4000; i++) begin
      clear_n          = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      field_sel        = 2'($urandom_range(0, 3));
      manual_increment = ($urandom_range(0, 2) == 0);
      manual_decrement = ($urandom_range(0, 2) == 0);
      start            = ($urandom_range(0, 7) == 0);
      stop             = ($urandom_range(0, 29) == 0);
      tick             = ($urandom_range(0, 1) == 0);
      step();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
